// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN ends multiply CALC once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             aneg_q, aneg_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] mrem_q, mrem_d;
`endif

    logic             accept;
    logic             arith_go;
    logic             dz_go;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             calc_last;
    logic             early;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   dshift;
    logic [WIDTH:0]   ddiff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept   = Start && (state_q == S_IDLE || state_q == S_DONE);
    assign arith_go = accept && !Op[2];
    assign dz_go    = arith_go && Op[1] && (B == '0);

    // Even opcodes (MULT, DIV) are the signed variants.
    assign a_neg = !Op[0] && A[WIDTH-1];
    assign b_neg = !Op[0] && B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

`ifdef MULDIV_EARLY_OUT_EN
    assign early = !div_q && (mrem_q[WIDTH-1:1] == '0);
`else
    assign early = 1'b0;
`endif
    assign calc_last = (cnt_q == CW'(WIDTH - 1)) || early;

    assign msum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mcand_q : '0)};
    assign dshift = {acc_q, mq_q[WIDTH-1]};
    assign ddiff  = dshift - {1'b0, mcand_q};

    // An early exit leaves the product short of its final right shifts.
`ifdef MULDIV_EARLY_OUT_EN
    assign prod = {acc_q, mq_q} >> (CW'(WIDTH) - cnt_q);
`else
    assign prod = {acc_q, mq_q};
`endif
    assign prod_fix = neg_q ? -prod : prod;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (arith_go) begin
                    state_d = dz_go ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (calc_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state_q == S_CALC) || (state_q == S_FIX);
        Done = (state_q == S_DONE);
    end

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        div_d   = div_q;
        neg_d   = neg_q;
        aneg_d  = aneg_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        cnt_d   = cnt_q;
`ifdef MULDIV_EARLY_OUT_EN
        mrem_d  = mrem_q;
`endif
        if (state_q == S_CALC) begin
            cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_EARLY_OUT_EN
            mrem_d = mrem_q >> 1;
`endif
            if (div_q) begin
                if (ddiff[WIDTH]) begin
                    acc_d = dshift[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = ddiff[WIDTH-1:0];
                    mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                end
            end else begin
                acc_d = msum[WIDTH:1];
                mq_d  = {msum[0], mq_q[WIDTH-1:1]};
            end
        end else if (state_q == S_FIX) begin
            if (div_q) begin
                lo_d = neg_q ? -mq_q : mq_q;
                hi_d = aneg_q ? -acc_q : acc_q;
            end else begin
                hi_d = prod_fix[2*WIDTH-1:WIDTH];
                lo_d = prod_fix[WIDTH-1:0];
            end
        end else if (accept) begin
            if (arith_go) begin
                dz_d    = dz_go;
                div_d   = Op[1];
                neg_d   = a_neg ^ b_neg;
                aneg_d  = a_neg;
                acc_d   = '0;
                cnt_d   = '0;
                mcand_d = Op[1] ? b_mag : a_mag;
                mq_d    = Op[1] ? a_mag : b_mag;
`ifdef MULDIV_EARLY_OUT_EN
                mrem_d  = b_mag;
`endif
                if (dz_go) begin
                    hi_d = A;
                    lo_d = '1;
                end
            end else if (Op == 3'd4) begin
                hi_d = A;
            end else if (Op == 3'd5) begin
                lo_d = A;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            aneg_q  <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            mrem_q  <= '0;
`endif
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            aneg_q  <= aneg_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
`ifdef MULDIV_EARLY_OUT_EN
            mrem_q  <= mrem_d;
`endif
        end
    end

    assign DivZero = dz_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width; legal values 8..64.
REQ-002 Clk  input  1  rising-edge clock.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request; sampled on Clk rising edge.
REQ-005 Op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved.
REQ-006 A  input  WIDTH  multiplicand / dividend / MTHI-MTLO source.
REQ-007 B  input  WIDTH  multiplier / divisor.
REQ-008 Busy  output  1  high while an operation is in flight.
REQ-009 Done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-010 DivZero  output  1  sticky flag for the last DIV/DIVU with B=0; cleared by the next accepted MULT/MULTU/DIV/DIVU.
REQ-011 HI  output  WIDTH  high result register (product high half / remainder).
REQ-012 LO  output  WIDTH  low result register (product low half / quotient).

Function
REQ-013 States: IDLE, CALC, FIX, DONE. Busy shall be high in CALC and FIX only.
REQ-014 Accept: the unit accepts a request at an edge when it is in IDLE or DONE and Start=1. Start in CALC or FIX shall be ignored, with no queuing.
REQ-015 MULT/MULTU/DIV/DIVU accepted at edge E0 shall move the unit to CALC. It then spends WIDTH cycles in CALC, one cycle in FIX, and enters DONE at edge E(WIDTH+1).
REQ-016 DONE shall last exactly one cycle with Done=1. From DONE the unit returns to IDLE, or goes to CALC if a new request is accepted.
REQ-017 HI/LO shall update only on the edge entering DONE, or on an MTHI/MTLO accept. Otherwise they hold.
REQ-018 CALC shall operate on operand magnitudes: signed ops take the absolute value of negative operands; unsigned ops use the operands raw.
REQ-019 Multiply shall be shift-add, one multiplier bit per cycle. The full 2*WIDTH product shall be written as {HI,LO}.
REQ-020 Divide shall be restoring, one quotient bit per cycle. LO=quotient, HI=remainder.
REQ-021 FIX for MULT shall negate the 2*WIDTH product when the operand signs differ.
REQ-022 FIX for DIV shall truncate the quotient toward zero: negate the quotient when the signs differ, and give the remainder the sign of A.
REQ-023 Signed overflow: DIV with A=most-negative value and B=-1 shall give LO=A, HI=0.
REQ-024 Divide by zero (DIV/DIVU, B=0) shall skip CALC and FIX: the unit enters DONE at E0 with HI=A, LO=all ones, DivZero=1.
REQ-025 MTHI/MTLO accepted at E0 shall write HI (or LO) with A at E0. The unit stays in IDLE, Done stays 0, and the other register is unchanged.
REQ-026 Reserved Op codes shall be accepted with no effect on state, HI, LO or DivZero.
REQ-027 Done and Busy shall never be high in the same cycle.

Reset
REQ-028 Reset=1 shall immediately, without waiting for Clk, force IDLE and clear Busy, Done, DivZero, HI and LO to 0.
REQ-029 Reset during CALC or FIX shall abort the operation, and no Done shall follow.
REQ-030 After Reset is released, the first rising edge shall be able to accept a request.

Configuration
REQ-031 Macro MULDIV_EARLY_OUT_EN: when defined, multiply shall leave CALC for FIX at the first CALC edge after which the remaining unconsumed multiplier bits are all zero. CALC still lasts at least one cycle, and results are identical.
REQ-032 Without MULDIV_EARLY_OUT_EN, multiply shall always spend exactly WIDTH cycles in CALC. Divide timing shall be the same in both builds.

Verification (WIDTH=32)
REQ-033 MULT A=0xFFFFFFFD, B=7 -> Done in the cycle after E33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; Busy high in the cycles after E0..E32 (no macro).
REQ-034 DIVU A=100, B=7 -> LO=14, HI=2; DIV A=0xFFFFFFF9, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 DIV A=5, B=0 -> Done in the cycle after E0, DivZero=1, HI=5, LO=0xFFFFFFFF; a following MULTU accept clears DivZero.
REQ-036 With MULDIV_EARLY_OUT_EN: MULTU A=3, B=5 -> DONE entered at E4, HI=0, LO=15.
REQ-037 Issue MULT, pulse Start with DIVU at E5, then assert Reset at E10 -> the DIVU is ignored; after Reset Busy=0, HI=LO=0 and no Done occurs.
REQ-038 MTHI A=0x12345678 from IDLE -> HI=0x12345678 after E0, LO unchanged, Done=0, Busy=0.
